line_delay: RTL

Block-RAM line delay for the pixel-stream datapath. Each `ce`-qualified sample is written to a LINE_LEN-deep circular buffer. The sample accepted exactly LINE_LEN accepts earlier is presented on `q`, which delays the stream by one full image row. Instances chain directly upstream of the 3-tap `shift_register` stages, so that row-delayed pixels feed the horizontal taps that build the sliding window. The block also provides row-fill status, column position and an end-of-line pulse.

---
 rtl/line_delay.sv | 81 ++++++++
 1 files changed

// File: rtl/line_delay.sv
// Row delay line: each ce-qualified sample comes back out LINE_LEN accepts later, with fill status,
// column position and end-of-line pulse. Define LINE_DELAY_ZERO_FILL_EN to zero q while the row fills.
module line_delay #(
    parameter int WIDTH    = 8,
    parameter int LINE_LEN = 640,
    parameter int CW       = $clog2(LINE_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             sof,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CW-1:0]    col,
    output logic             eol
);

    localparam logic [0:0]  FILL = 1'b0;
    localparam logic [0:0]  RUN  = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);
    // One extra bit so the fill count can hold LINE_LEN itself.
    localparam logic [CW:0]   FULL = (CW+1)'(LINE_LEN);

    logic [WIDTH-1:0] mem [0:LINE_LEN-1];
    logic [CW-1:0]    wptr;
    logic [CW-1:0]    addr;
    logic [CW-1:0]    addr_next;
    logic [CW:0]      fcnt;
    logic [0:0]       state;
    logic             valid_next;

    // A sof sample always lands at column 0 and restarts the row.
    always_comb begin
        addr       = sof ? '0 : wptr;
        addr_next  = (addr == LAST) ? '0 : addr + CW'(1);
        valid_next = (state == RUN) && !sof;
    end

    // NOTE: the buffer has no reset so it maps onto block RAM; stale rows are handled by the fill state.
    always_ff @(posedge clk) begin
        if (ce && !reset)
            mem[addr] <= d;
    end

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            q       <= '0;
            q_valid <= 1'b0;
            wptr    <= '0;
            eol     <= 1'b0;
            fcnt    <= '0;
            state   <= FILL;
        end else begin
            eol <= 1'b0;
            if (ce) begin
`ifdef LINE_DELAY_ZERO_FILL_EN
                q <= valid_next ? mem[addr] : '0;
`else
                q <= mem[addr];
`endif
                q_valid <= valid_next;
                wptr    <= addr_next;
                eol     <= (addr == LAST);
                if (sof) begin
                    fcnt  <= (CW+1)'(1);
                    state <= FILL;
                end else begin
                    if (fcnt != FULL)
                        fcnt <= fcnt + (CW+1)'(1);
                    if (fcnt == FULL - (CW+1)'(1))
                        state <= RUN;
                end
            end
        end
    end

    assign col = wptr;

endmodule
